// File: rtl/depthwise_pe_array.sv
// depthwise_pe_array: CHANNELS parallel signed MAC lanes with round/shift/ReLU/saturate post-processing and valid/ready flow control
module depthwise_pe_array #(
    parameter int CHANNELS    = 3,
    parameter int DATA_W      = 8,
    parameter int WEIGHT_W    = 8,
    parameter int KERNEL_TAPS = 9,
    parameter int ACC_W       = 20,
    parameter int OUT_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    input  logic [CHANNELS*WEIGHT_W-1:0] in_weight,
    input  logic [4:0]                   cfg_shift,
    input  logic                         cfg_round,
    input  logic                         cfg_relu,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*OUT_W-1:0]    out_data,
    output logic [CHANNELS-1:0]          out_sat,
    output logic                         busy
);
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int CNT_W = $clog2(KERNEL_TAPS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(KERNEL_TAPS - 1);
    localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

    logic [CNT_W-1:0] tap_cnt_q, tap_cnt_d;
    logic signed [ACC_W-1:0] acc_q [CHANNELS];
    logic signed [ACC_W-1:0] sum_w [CHANNELS];
    logic [4:0] shift_q, sh;
    logic round_q, relu_q, rnd_en, relu_en;
    logic out_valid_q, out_valid_d;
    logic [CHANNELS*OUT_W-1:0] out_data_q, res_w;
    logic [CHANNELS-1:0] out_sat_q, sat_w;
    logic accept, first, last;

    assign first    = tap_cnt_q == '0;
    assign last     = tap_cnt_q == LAST;
    assign in_ready = !(last && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    // The window's first tap uses the live config, since the latch only updates on that same edge
    assign sh       = first ? cfg_shift : shift_q;
    assign rnd_en   = first ? cfg_round : round_q;
    assign relu_en  = first ? cfg_relu : relu_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic signed [PROD_W-1:0] prod;
        logic [ACC_W:0] half;
        logic signed [ACC_W:0] rnd, shd, pos;
        assign prod = $signed(in_data[c*DATA_W +: DATA_W]) * $signed(in_weight[c*WEIGHT_W +: WEIGHT_W]);
        assign sum_w[c] = (first ? '0 : acc_q[c]) + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        assign half = (rnd_en && sh != 5'd0) ? ({{ACC_W{1'b0}}, 1'b1} << (sh - 5'd1)) : '0;
        assign rnd = $signed({sum_w[c][ACC_W-1], sum_w[c]} + half);
        assign shd = rnd >>> sh;
        assign pos = (relu_en && shd[ACC_W]) ? '0 : shd;
        assign sat_w[c] = (pos > MAX_V) || (pos < MIN_V);
        assign res_w[c*OUT_W +: OUT_W] = pos > MAX_V ? MAX_V[OUT_W-1:0] :
                                         pos < MIN_V ? MIN_V[OUT_W-1:0] : pos[OUT_W-1:0];
    end

    always_comb begin
        tap_cnt_d   = accept ? (last ? '0 : tap_cnt_q + 1'b1) : tap_cnt_q;
        out_valid_d = (accept && last) ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_cnt_q   <= '0;
            shift_q     <= '0;
            round_q     <= 1'b0;
            relu_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
        end else begin
            tap_cnt_q   <= tap_cnt_d;
            out_valid_q <= out_valid_d;
            if (accept) for (int i = 0; i < CHANNELS; i++) acc_q[i] <= sum_w[i];
            if (accept && first) begin
                shift_q <= cfg_shift;
                round_q <= cfg_round;
                relu_q  <= cfg_relu;
            end
            if (accept && last) begin
                out_data_q <= res_w;
                out_sat_q  <= sat_w;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign busy      = tap_cnt_q != '0;
endmodule
